// File: rtl/if_stage.sv
// if_stage: pre-IF + IF stage of the five-stage pipeline.
// Generates fetch PCs, drives the instruction SRAM-like port and hands
// {inst, pc} to the decode stage.
// When decode redirects the pipeline it squashes the wrong-path fetch
// and discards any late SRAM response.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  // Pre-IF state: the next address to request.
  logic        pfs_valid_q, pfs_valid_d;
  logic [31:0] pfs_pc_q,    pfs_pc_d;
  // IF state: the instruction in flight or waiting for decode.
  logic        fs_valid_q,  fs_valid_d;
  logic [31:0] fs_pc_q,     fs_pc_d;
  logic        fs_wait_q,   fs_wait_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_q,       buf_d;
  // Set while a squashed request still has its response outstanding.
  logic        cancel_q,    cancel_d;

  logic        br_taken_s;
  logic [31:0] br_target_s;
  logic        redirect_s;
  logic        fs_ready_go_s;
  logic        fs_allowin_s;
  logic        fs_xfer_s;
  logic        fs_hs_s;
  logic [31:0] fs_inst_s;

  assign br_taken_s  = br_bus[32];
  assign br_target_s = br_bus[31:0];

  // Handshake and control terms derived from current state and inputs.
  always_comb begin
    // The branch only takes effect when it leaves ID this cycle.
    redirect_s     = br_taken_s & ds_allowin;
    fs_ready_go_s  = fs_valid_q & (buf_valid_q | (fs_wait_q & inst_sram_data_ok));
    fs_allowin_s   = ~fs_valid_q | (fs_ready_go_s & ds_allowin);
    // A taken branch still sitting in ID makes our word wrong-path.
    fs_to_ds_valid = fs_ready_go_s & ~br_taken_s;
    fs_xfer_s      = fs_to_ds_valid & ds_allowin;
    inst_sram_req  = pfs_valid_q & fs_allowin_s & ~cancel_q & ~redirect_s;
    fs_hs_s        = inst_sram_req & inst_sram_addr_ok;
    if (buf_valid_q) begin
      fs_inst_s = buf_q;
    end else begin
      fs_inst_s = inst_sram_rdata;
    end
  end

  assign inst_sram_addr = pfs_pc_q;
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = 2'd2;
  assign fs_to_ds_bus   = {fs_inst_s, fs_pc_q};

  // Next-state logic: redirect overrides response, transfer and handshake.
  always_comb begin
    pfs_valid_d = 1'b1;
    pfs_pc_d    = pfs_pc_q;
    fs_valid_d  = fs_valid_q;
    fs_pc_d     = fs_pc_q;
    fs_wait_d   = fs_wait_q;
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    cancel_d    = cancel_q;
    if (redirect_s) begin
      pfs_pc_d    = br_target_s;
      fs_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
      fs_wait_d   = 1'b0;
      // Keep cancelling if an earlier squashed response is still pending,
      // so a repeated redirect cannot let that stale word through.
      cancel_d    = (fs_wait_q | cancel_q) & ~inst_sram_data_ok;
    end else begin
      if (inst_sram_data_ok && cancel_q) begin
        cancel_d = 1'b0;
      end else if (inst_sram_data_ok && fs_wait_q) begin
        fs_wait_d = 1'b0;
        if (!fs_xfer_s) begin
          buf_d       = inst_sram_rdata;
          buf_valid_d = 1'b1;
        end else begin
          buf_valid_d = buf_valid_q;
        end
      end else begin
        // No response, or a response with nothing outstanding: ignored.
        cancel_d = cancel_q;
      end
      if (fs_xfer_s) begin
        fs_valid_d  = 1'b0;
        buf_valid_d = 1'b0;
      end else begin
        fs_valid_d = fs_valid_q;
      end
      if (fs_hs_s) begin
        pfs_pc_d    = pfs_pc_q + 32'd4;
        fs_valid_d  = 1'b1;
        fs_pc_d     = pfs_pc_q;
        fs_wait_d   = 1'b1;
        buf_valid_d = 1'b0;
      end else begin
        pfs_pc_d = pfs_pc_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pfs_valid_q <= 1'b0;
      pfs_pc_q    <= RESET_PC;
      fs_valid_q  <= 1'b0;
      fs_pc_q     <= 32'h0000_0000;
      fs_wait_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_q       <= 32'h0000_0000;
      cancel_q    <= 1'b0;
    end else begin
      pfs_valid_q <= pfs_valid_d;
      pfs_pc_q    <= pfs_pc_d;
      fs_valid_q  <= fs_valid_d;
      fs_pc_q     <= fs_pc_d;
      fs_wait_q   <= fs_wait_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      cancel_q    <= cancel_d;
    end
  end

endmodule
